// File: rtl/layer_output_mac_pkg.sv
// Shared definitions for the output-layer MAC stage: sizes, FSM state, activation helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package layer_output_mac_pkg;

  localparam int N_IN    = 2;                          // MAC steps per inference
  localparam int N_OUT   = 2;                          // parallel output neurons
  localparam int DW      = 8;                          // signed Q(DW-FRAC).FRAC data
  localparam int FRAC    = 4;                          // fractional bits
  localparam int ACC_W   = 2*DW + $clog2(N_IN+1);      // wide enough that only ACT saturates
  localparam int N_WORDS = N_OUT*(N_IN+1);             // weights then biases
  localparam int PTR_W   = $clog2(N_WORDS);
  localparam int STEP_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, ACT} state_t;

  localparam logic signed [ACC_W-1:0] ACC_YMAX = ACC_W'((1 << (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_YMIN = ~ACC_YMAX;  // -(2^(DW-1))
  localparam logic [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

  // Clamp a wide signed accumulator into a DW-bit signed word.
  function automatic logic [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] acc);
    if (acc > ACC_YMAX)      return Y_MAX;
    else if (acc < ACC_YMIN) return Y_MIN;
    else                     return acc[DW-1:0];
  endfunction

  // Negative values become zero.
  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/layer_output_mac_if.sv
// Handshake/data bundle between the hidden layer/host (master) and the output MAC (slave).
// Latency: n/a (wires only).
// Backpressure: busy tells the master that req is being ignored.
interface layer_output_mac_if;
  import layer_output_mac_pkg::*;

  logic                  fill;       // parameter-load mode
  logic                  fill_we;    // write strobe for fill_data
  logic [DW-1:0]         fill_data;  // weight/bias word
  logic                  req;        // hidden-layer done strobe, a_vec valid
  logic [N_IN*DW-1:0]    a_vec;      // a[i] at [i*DW +: DW]
  logic                  busy;       // inference in progress
  logic                  ack;        // one-cycle pulse, y_vec updated
  logic [N_OUT*DW-1:0]   y_vec;      // y[o] at [o*DW +: DW]

  modport master (output fill, fill_we, fill_data, req, a_vec,
                  input  busy, ack, y_vec);
  modport slave  (input  fill, fill_we, fill_data, req, a_vec,
                  output busy, ack, y_vec);
endinterface

// File: rtl/layer_output_mac_lane.sv
// One output neuron: accumulates w*a products, adds bias, saturates and activates.
// Latency: result registered on the BIAS cycle so it is visible alongside ack.
// Backpressure: none; strobes come from the parent FSM.
// Ports: clk/rst; clr_i/mac_i/bias_i strobes; w_i, a_i, b_i operands; y_o held result.
module layer_output_mac_lane
  import layer_output_mac_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          mac_i,
  input  logic          bias_i,
  input  logic [DW-1:0] w_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] y_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d, prod_ext, b_ext, sum_b;
  logic signed [2*DW-1:0]  w_ext, a_ext, prod, prod_sh;
  logic [DW-1:0]           y_q, y_d, y_sat;

  always_comb begin
    // DW x DW signed product fits exactly in 2*DW bits.
    w_ext    = {{DW{w_i[DW-1]}}, w_i};
    a_ext    = {{DW{a_i[DW-1]}}, a_i};
    prod     = w_ext * a_ext;
    prod_sh  = prod >>> FRAC;
    prod_ext = {{(ACC_W-2*DW){prod_sh[2*DW-1]}}, prod_sh};
    b_ext    = {{(ACC_W-DW){b_i[DW-1]}}, b_i};
    sum_b    = acc_q + b_ext;
    y_sat    = sat_dw(sum_b);
    acc_d    = acc_q;
    y_d      = y_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (mac_i) begin
      acc_d = acc_q + prod_ext;
    end else if (bias_i) begin
      acc_d = sum_b;
      // Activation computed from the biased sum so y lands with ack.
      y_d   = RELU ? relu(y_sat) : y_sat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/layer_output_mac.sv
// Output layer: latches hidden activations on req, runs N_OUT parallel MAC lanes, ReLU/sat.
// Latency: req at cycle 0 -> ack at cycle N_IN+2; one inference per N_IN+3 cycles.
// Backpressure: busy high while computing; req ignored (not queued) while busy or fill.
// Ports: clk, rst (async active-low), bus (slave modport: fill/fill_we/fill_data, req/a_vec,
//        busy/ack/y_vec).
module layer_output_mac
  import layer_output_mac_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  layer_output_mac_if.slave  bus
);

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [DW-1:0]       a_q [N_IN];
  logic                busy_q, ack_q;
  logic [PTR_W-1:0]    ptr_q;
  logic                fill_q;
  logic [DW-1:0]       ram_q [N_WORDS];   // weights row-major, then biases; not reset

  logic                start, wr_en;
  logic [DW-1:0]       a_cur;
  logic [N_OUT*DW-1:0] y_vec;

  // Fill has priority over req in IDLE; writes only land while idle.
  assign start = (state_q == IDLE) && bus.req && !bus.fill;
  assign wr_en = (state_q == IDLE) && bus.fill && bus.fill_we;
  assign a_cur = a_q[step_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      for (int i = 0; i < N_IN; i++) a_q[i] <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          for (int i = 0; i < N_IN; i++) a_q[i] <= bus.a_vec[i*DW +: DW];
          step_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= MAC;
        end
        MAC: begin
          step_q <= step_q + 1'b1;
          if (step_q == STEP_W'(N_IN-1)) state_q <= BIAS;
        end
        BIAS: begin
          ack_q   <= 1'b1;   // lanes register y on this edge too
          state_q <= ACT;
        end
        ACT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      fill_q <= 1'b0;
    end else begin
      fill_q <= bus.fill;
      if (fill_q && !bus.fill)
        ptr_q <= '0;
      else if (wr_en)
        ptr_q <= (ptr_q == PTR_W'(N_WORDS-1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram_q[ptr_q] <= bus.fill_data;
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_lane
    logic [PTR_W-1:0] w_idx;
    assign w_idx = PTR_W'(o*N_IN) + PTR_W'(step_q);

    layer_output_mac_lane #(.RELU(RELU)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start),
      .mac_i  (state_q == MAC),
      .bias_i (state_q == BIAS),
      .w_i    (ram_q[w_idx]),
      .a_i    (a_cur),
      .b_i    (ram_q[PTR_W'(N_OUT*N_IN + o)]),
      .y_o    (y_vec[o*DW +: DW])
    );
  end

  assign bus.busy  = busy_q;
  assign bus.ack   = ack_q;
  assign bus.y_vec = y_vec;

endmodule

// File: tb/tb_layer_output_mac.sv
// Bench for layer_output_mac: a ReLU and a linear instance share stimulus, checked against
// an arithmetic reference model of the neuron equation.
// Latency/backpressure checked: ack cycle, busy window, req ignored while busy or filling.
module tb_layer_output_mac;
  import layer_output_mac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fill = 1'b0, fill_we = 1'b0, req = 1'b0;
  logic [7:0]  fill_data = '0;
  logic [15:0] a_vec = '0;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem_m [N_WORDS];
  int         ptr_m = 0;

  always #5 clk = ~clk;

  layer_output_mac_if bus_r ();
  layer_output_mac_if bus_l ();

  assign bus_r.fill = fill;  assign bus_r.fill_we = fill_we;  assign bus_r.fill_data = fill_data;
  assign bus_r.req  = req;   assign bus_r.a_vec   = a_vec;
  assign bus_l.fill = fill;  assign bus_l.fill_we = fill_we;  assign bus_l.fill_data = fill_data;
  assign bus_l.req  = req;   assign bus_l.a_vec   = a_vec;

  layer_output_mac #(.RELU(1'b1)) dut_relu (.clk(clk), .rst(rst), .bus(bus_r));
  layer_output_mac #(.RELU(1'b0)) dut_lin  (.clk(clk), .rst(rst), .bus(bus_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // y[o] = act(sat(sum_i (w*a) >> FRAC + b)) in plain integer arithmetic.
  function automatic logic [7:0] ref_y(input int o, input logic [15:0] a, input bit use_relu);
    int s, wv, av;
    s = 0;
    for (int i = 0; i < N_IN; i++) begin
      wv = int'($signed(mem_m[o*N_IN + i]));
      av = int'($signed(a[i*8 +: 8]));
      s += (wv * av) >>> 4;
    end
    s += int'($signed(mem_m[N_OUT*N_IN + o]));
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    if (use_relu && s < 0) s = 0;
    return 8'(s);
  endfunction

  task automatic fill_word(input logic [7:0] d);
    fill = 1'b1; fill_we = 1'b1; fill_data = d;
    mem_m[ptr_m] = d;
    ptr_m = (ptr_m + 1) % N_WORDS;
    tick();
  endtask

  task automatic end_fill();
    fill = 1'b0; fill_we = 1'b0;
    ptr_m = 0;
    tick();
  endtask

  task automatic load6(input logic [7:0] w0, w1, w2, w3, b0, b1);
    fill_word(w0); fill_word(w1); fill_word(w2); fill_word(w3);
    fill_word(b0); fill_word(b1);
    end_fill();
  endtask

  task automatic start_req(input logic [15:0] a);
    a_vec = a; req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!bus_r.ack && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic check_y(input string tag, input logic [15:0] a);
    for (int o = 0; o < N_OUT; o++) begin
      chk({tag, "_yrelu"}, bus_r.y_vec[o*8 +: 8], ref_y(o, a, 1'b1));
      chk({tag, "_ylin"},  bus_l.y_vec[o*8 +: 8], ref_y(o, a, 1'b0));
    end
  endtask

  // Full inference from the current idle window; ack expected 4 windows after req.
  task automatic infer(input string tag, input logic [15:0] a);
    int n;
    start_req(a);
    chk({tag, "_busy"}, bus_r.busy, 1);
    wait_ack(n);
    chk({tag, "_lat"}, 1 + n, N_IN + 2);
    chk({tag, "_ackl"}, bus_l.ack, 1);
    check_y(tag, a);
    tick();
    chk({tag, "_ack_off"}, bus_r.ack, 0);
    chk({tag, "_idle"}, bus_r.busy, 0);
  endtask

  initial begin
    int n, acks;
    logic [15:0] a;

    // Reset state
    tick(); tick();
    chk("rst_busy", bus_r.busy, 0);
    chk("rst_ack", bus_r.ack, 0);
    chk("rst_y", bus_r.y_vec, 0);
    chk("rst_yl", bus_l.y_vec, 0);
    rst = 1'b1;
    tick();

    // 1: all weights and biases 1.0
    load6(8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10);
    infer("t1", 16'h2010);
    chk("t1_y0", bus_r.y_vec[7:0], 8'h40);
    chk("t1_y1", bus_r.y_vec[15:8], 8'h40);

    // 2: neuron 1 negative, ReLU clamps it
    load6(8'h10, 8'h10, 8'hF0, 8'hF0, 8'h10, 8'h00);
    infer("t2", 16'h2010);
    chk("t2_y0", bus_r.y_vec[7:0], 8'h40);
    chk("t2_y1", bus_r.y_vec[15:8], 8'h00);
    chk("t2_y1lin", bus_l.y_vec[15:8], 8'hD0);

    // 3: positive and negative saturation
    load6(8'h70, 8'h70, 8'h70, 8'h70, 8'h70, 8'h70);
    infer("t3p", 16'h7070);
    chk("t3_pos", bus_r.y_vec[7:0], 8'h7F);
    load6(8'h90, 8'h90, 8'h90, 8'h90, 8'h70, 8'h70);
    infer("t3n", 16'h7070);
    chk("t3_neg_lin", bus_l.y_vec[7:0], 8'h80);
    chk("t3_neg_relu", bus_r.y_vec[7:0], 8'h00);

    // 4: second req while busy ignored; req right after ack accepted
    load6(8'h10, 8'h20, 8'h08, 8'hF8, 8'h04, 8'hFC);
    start_req(16'h2010);                    // window 1
    tick();                                 // window 2
    a_vec = 16'h4444; req = 1'b1;
    tick();                                 // window 3
    req = 1'b0;
    chk("t4_ack_early", bus_r.ack, 0);
    tick();                                 // window 4
    chk("t4_ack", bus_r.ack, 1);
    check_y("t4a", 16'h2010);
    tick();                                 // window 5
    chk("t4_ack_once", bus_r.ack, 0);
    infer("t4b", 16'h3050);

    // 5: reset mid-inference aborts immediately, weights survive
    start_req(16'h1818);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_busy", bus_r.busy, 0);
    chk("t5_y", bus_r.y_vec, 0);
    chk("t5_yl", bus_l.y_vec, 0);
    chk("t5_ack", bus_r.ack, 0);
    ptr_m = 0;
    tick(); tick();
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_r.ack) acks++;
    end
    chk("t5_no_ack", acks, 0);
    infer("t5b", 16'h1818);

    // 6: seven words wrap onto w[0][0]
    for (int i = 0; i < 7; i++) fill_word(8'($urandom_range(0, 255)));
    end_fill();
    infer("t6a", 16'h2424);
    // fill_we while busy is dropped
    start_req(16'h1C0C);
    fill = 1'b1; fill_we = 1'b1; fill_data = 8'h55;
    tick(); tick();
    fill = 1'b0; fill_we = 1'b0;
    wait_ack(n);
    chk("t6_lat", 3 + n, N_IN + 2);
    check_y("t6b", 16'h1C0C);
    tick(); tick();
    ptr_m = 0;
    infer("t6c", 16'h1C0C);
    // fill rising together with req in IDLE: fill wins
    a_vec = 16'h1111; req = 1'b1;
    fill_word(8'h20);
    req = 1'b0;
    chk("t6_req_drop", bus_r.busy, 0);
    fill_word(8'h10); fill_word(8'hE0); fill_word(8'h30);
    fill_word(8'h02); fill_word(8'hFE);
    end_fill();
    chk("t6_no_ack", bus_r.ack, 0);
    infer("t6d", 16'h2030);

    // Random weights, biases and activations
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1)
        load6(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));
      a = 16'($urandom);
      infer("rnd", a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
